// File: rtl/exec_pipe_core.sv
// Two-stage (RD -> EX) integer execution core with an internal register file, EX->RD bypass
// and a valid/ready writeback port that can apply backpressure.
module exec_pipe_core #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          ZERO_R = 1'b1,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [3:0]        uop_opcode,
  input  logic [AW-1:0]     uop_rs1,
  input  logic [AW-1:0]     uop_rs2,
  input  logic [AW-1:0]     uop_rd,
  input  logic [XLEN-1:0]   uop_imm,
  input  logic              uop_imm_sel,
  input  logic              uop_wr_en,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [AW-1:0]     wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpSll  = 4'd2,
    OpSlt  = 4'd3,
    OpSltu = 4'd4,
    OpXor  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpOr   = 4'd8,
    OpAnd  = 4'd9,
    OpPass = 4'd10
  } op_e;

  logic [XLEN-1:0] rf_q [NREG];

  logic            ready_en_q;
  logic            ex_valid_q;
  logic [3:0]      ex_op_q;
  logic [XLEN-1:0] ex_a_q;
  logic [XLEN-1:0] ex_b_q;
  logic [AW-1:0]   ex_rd_q;
  logic            ex_wr_q;

  logic            wb_valid_q;
  logic [AW-1:0]   wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            wb_illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [XLEN-1:0] ex_result;
  logic            ex_illegal;
  logic            ex_advance;
  logic            ex_fwd;
  logic            accept;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] op2_data;
  logic [SW-1:0]   shamt;

  // ALU on the operands latched in EX
  always_comb begin
    ex_result  = '0;
    ex_illegal = 1'b0;
    shamt      = ex_b_q[SW-1:0];
    case (ex_op_q)
      OpAdd:   ex_result = ex_a_q + ex_b_q;
      OpSub:   ex_result = ex_a_q - ex_b_q;
      OpSll:   ex_result = ex_a_q << shamt;
      OpSlt:   ex_result = {{(XLEN-1){1'b0}}, $signed(ex_a_q) < $signed(ex_b_q)};
      OpSltu:  ex_result = {{(XLEN-1){1'b0}}, ex_a_q < ex_b_q};
      OpXor:   ex_result = ex_a_q ^ ex_b_q;
      OpSrl:   ex_result = ex_a_q >> shamt;
      OpSra:   ex_result = $unsigned($signed(ex_a_q) >>> shamt);
      OpOr:    ex_result = ex_a_q | ex_b_q;
      OpAnd:   ex_result = ex_a_q & ex_b_q;
      OpPass:  ex_result = ex_b_q;
      default: begin
        ex_result  = '0;
        ex_illegal = 1'b1;
      end
    endcase
  end

  assign ex_advance = ex_valid_q & (~wb_valid_q | wb_ready);
  assign uop_ready  = ready_en_q & (~ex_valid_q | ex_advance);
  assign accept     = uop_valid & uop_ready;
  assign ex_fwd     = ex_valid_q & ex_wr_q & ~ex_illegal;

  // Operand read with bypass from the EX result; register 0 never forwards when hardwired
  always_comb begin
    rs1_data = rf_q[uop_rs1];
    rs2_data = rf_q[uop_rs2];
    if (ZERO_R && uop_rs1 == '0) begin
      rs1_data = '0;
    end else if (ex_fwd && ex_rd_q == uop_rs1) begin
      rs1_data = ex_result;
    end
    if (ZERO_R && uop_rs2 == '0) begin
      rs2_data = '0;
    end else if (ex_fwd && ex_rd_q == uop_rs2) begin
      rs2_data = ex_result;
    end
    op2_data = uop_imm_sel ? uop_imm : rs2_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_op_q    <= uop_opcode;
        ex_a_q     <= rs1_data;
        ex_b_q     <= op2_data;
        ex_rd_q    <= uop_rd;
        ex_wr_q    <= uop_wr_en;
      end else if (ex_advance) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_illegal_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      if (wb_valid_q && wb_ready) begin
        retired_q <= retired_q + 1'b1;
      end
      if (ex_advance) begin
        wb_valid_q   <= 1'b1;
        wb_rd_q      <= ex_rd_q;
        wb_data_q    <= ex_result;
        wb_illegal_q <= ex_illegal;
      end else if (wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (ex_advance && ex_fwd && !(ZERO_R && ex_rd_q == '0)) begin
      rf_q[ex_rd_q] <= ex_result;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_illegal = wb_illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_exec_pipe_core.sv
// Directed bench for exec_pipe_core: reset, ALU ops, bypass, backpressure, illegal ops.
module tb_exec_pipe_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uop_valid = 1'b0;
  logic        uop_ready;
  logic [3:0]  uop_opcode = '0;
  logic [4:0]  uop_rs1 = '0;
  logic [4:0]  uop_rs2 = '0;
  logic [4:0]  uop_rd = '0;
  logic [31:0] uop_imm = '0;
  logic        uop_imm_sel = 1'b0;
  logic        uop_wr_en = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_illegal;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } wb_t;
  wb_t wbq[$];

  exec_pipe_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_opcode (uop_opcode),
    .uop_rs1    (uop_rs1),
    .uop_rs2    (uop_rs2),
    .uop_rd     (uop_rd),
    .uop_imm    (uop_imm),
    .uop_imm_sel(uop_imm_sel),
    .uop_wr_en  (uop_wr_en),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_illegal (wb_illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Results that will be handshaken at the next rising edge
  always @(negedge clk) begin
    if (wb_valid && wb_ready) wbq.push_back('{rd: wb_rd, data: wb_data, ill: wb_illegal});
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic isel,
                      input logic wr, output int waited);
    waited = 0;
    uop_valid = 1'b1; uop_opcode = op; uop_rs1 = rs1; uop_rs2 = rs2; uop_rd = rd;
    uop_imm = imm; uop_imm_sel = isel; uop_wr_en = wr;
    while (!uop_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (!uop_ready) begin
      $display("FAIL send_timeout: uop_ready stayed %b, required 1", uop_ready);
      n_fail++; n_checks++;
    end
    @(posedge clk); #1;
    uop_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (wbq.size() < n && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (wbq.size() < n) begin
      $display("FAIL wb_timeout: got %0d results, required %0d", wbq.size(), n);
      n_fail++; n_checks++;
      while (wbq.size() < n) wbq.push_back('{rd: 'x, data: 'x, ill: 'x});
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; uop_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    wbq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wb_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (uop_ready !== 1'b0) begin
      $display("FAIL rst_ready: got %b want 0", uop_ready); n_fail++; end
    n_checks++; if (wb_valid !== 1'b0) begin
      $display("FAIL rst_wb_valid: got %b want 0", wb_valid); n_fail++; end
    n_checks++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_illegal !== 1'b0) begin
      $display("FAIL rst_wb_regs: got rd=%0d data=%h ill=%b want 0", wb_rd, wb_data, wb_illegal);
      n_fail++; end
    n_checks++; if (retired !== 32'd0) begin
      $display("FAIL rst_retired: got %0d want 0", retired); n_fail++; end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (uop_ready !== 1'b1) begin
      $display("FAIL rst_release_ready: got %b want 1", uop_ready); n_fail++; end
  endtask

  task automatic test_pass();
    int w;
    send(4'd10, 5'd0, 5'd0, 5'd5, 32'h1234, 1'b1, 1'b1, w);
    n_checks++; if (wb_valid !== 1'b0) begin
      $display("FAIL pass_early: wb_valid got %b want 0", wb_valid); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000_1234) begin
      $display("FAIL pass_wb: got v=%b rd=%0d data=%h want v=1 rd=5 data=00001234",
               wb_valid, wb_rd, wb_data); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (retired !== 32'd1 || wb_valid !== 1'b0) begin
      $display("FAIL pass_retire: got retired=%0d v=%b want 1,0", retired, wb_valid); n_fail++; end
    wbq.delete();
    send(4'd10, 5'd0, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, w);
    wait_q(1);
    n_checks++; if (wbq[0].data !== 32'h1234) begin
      $display("FAIL pass_readback: got %h want 00001234", wbq[0].data); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int w;
    wbq.delete();
    send(4'd0, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 1'b1, w);
    send(4'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, w);
    n_checks++; if (w !== 0) begin
      $display("FAIL b2b_gap: waited %0d cycles want 0", w); n_fail++; end
    wait_q(2);
    n_checks++; if (wbq[0].rd !== 5'd1 || wbq[0].data !== 32'd7) begin
      $display("FAIL b2b_first: got rd=%0d data=%0d want 1,7", wbq[0].rd, wbq[0].data);
      n_fail++; end
    n_checks++; if (wbq[1].rd !== 5'd2 || wbq[1].data !== 32'd14) begin
      $display("FAIL b2b_second: got rd=%0d data=%0d want 2,14", wbq[1].rd, wbq[1].data);
      n_fail++; end
  endtask

  task automatic test_alu();
    int w;
    wbq.delete();
    send(4'd10, 5'd0, 5'd0, 5'd3, 32'h8000_0000, 1'b1, 1'b1, w);
    send(4'd7, 5'd3, 5'd0, 5'd6, 32'd4, 1'b1, 1'b1, w);
    send(4'd6, 5'd3, 5'd0, 5'd7, 32'd4, 1'b1, 1'b1, w);
    send(4'd0, 5'd0, 5'd0, 5'd8, 32'd1, 1'b1, 1'b1, w);
    send(4'd4, 5'd8, 5'd0, 5'd9, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    send(4'd3, 5'd8, 5'd0, 5'd10, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    send(4'd1, 5'd8, 5'd0, 5'd11, 32'd3, 1'b1, 1'b1, w);
    wait_q(7);
    n_checks++; if (wbq[1].data !== 32'hF800_0000) begin
      $display("FAIL alu_sra: got %h want f8000000", wbq[1].data); n_fail++; end
    n_checks++; if (wbq[2].data !== 32'h0800_0000) begin
      $display("FAIL alu_srl: got %h want 08000000", wbq[2].data); n_fail++; end
    n_checks++; if (wbq[4].data !== 32'd1) begin
      $display("FAIL alu_sltu: got %h want 00000001", wbq[4].data); n_fail++; end
    n_checks++; if (wbq[5].data !== 32'd0) begin
      $display("FAIL alu_slt: got %h want 00000000", wbq[5].data); n_fail++; end
    n_checks++; if (wbq[6].data !== 32'hFFFF_FFFE) begin
      $display("FAIL alu_sub: got %h want fffffffe", wbq[6].data); n_fail++; end
  endtask

  task automatic test_zero_reg();
    int w;
    wbq.delete();
    send(4'd0, 5'd0, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, w);
    send(4'd10, 5'd0, 5'd0, 5'd12, 32'd0, 1'b0, 1'b0, w);
    send(4'd10, 5'd0, 5'd0, 5'd12, 32'd0, 1'b0, 1'b0, w);
    wait_q(3);
    n_checks++; if (wbq[0].data !== 32'd5) begin
      $display("FAIL zero_wbdata: got %h want 00000005", wbq[0].data); n_fail++; end
    n_checks++; if (wbq[1].data !== 32'd0 || wbq[2].data !== 32'd0) begin
      $display("FAIL zero_read: got %h,%h want 0,0", wbq[1].data, wbq[2].data); n_fail++; end
  endtask

  task automatic test_illegal();
    int w;
    wbq.delete();
    send(4'd10, 5'd0, 5'd0, 5'd4, 32'h44, 1'b1, 1'b1, w);
    send(4'd13, 5'd0, 5'd0, 5'd4, 32'h99, 1'b1, 1'b1, w);
    send(4'd10, 5'd0, 5'd4, 5'd13, 32'd0, 1'b0, 1'b0, w);
    wait_q(3);
    n_checks++; if (wbq[1].ill !== 1'b1 || wbq[1].data !== 32'd0 || wbq[1].rd !== 5'd4) begin
      $display("FAIL ill_wb: got ill=%b data=%h rd=%0d want 1,0,4",
               wbq[1].ill, wbq[1].data, wbq[1].rd); n_fail++; end
    n_checks++; if (wbq[2].data !== 32'h44 || wbq[2].ill !== 1'b0) begin
      $display("FAIL ill_keep: got data=%h ill=%b want 00000044,0", wbq[2].data, wbq[2].ill);
      n_fail++; end
  endtask

  task automatic test_stall();
    int idx = 0;
    int acc = 0;
    int w;
    logic rdy;
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    do_reset();
    wb_ready = 1'b0;
    uop_valid = 1'b1; uop_opcode = 4'd10; uop_imm_sel = 1'b1; uop_wr_en = 1'b1;
    uop_rd = 5'd20; uop_imm = vals[0];
    for (int c = 0; c < 5; c++) begin
      rdy = uop_ready;
      @(posedge clk); #1;
      if (rdy && idx < 3) begin
        acc++; idx++;
        if (idx < 3) begin uop_rd = 5'd20 + 5'(idx); uop_imm = vals[idx]; end
      end
    end
    n_checks++; if (acc !== 2 || uop_ready !== 1'b0) begin
      $display("FAIL stall_accept: got acc=%0d ready=%b want 2,0", acc, uop_ready); n_fail++; end
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h11 || wb_rd !== 5'd20) begin
      $display("FAIL stall_hold: got v=%b data=%h rd=%0d want 1,11,20", wb_valid, wb_data, wb_rd);
      n_fail++; end
    n_checks++; if (retired !== 32'd0 || wbq.size() != 0) begin
      $display("FAIL stall_noretire: got retired=%0d q=%0d want 0,0", retired, wbq.size());
      n_fail++; end
    wb_ready = 1'b1;
    send(4'd10, 5'd0, 5'd0, 5'd22, 32'h33, 1'b1, 1'b1, w);
    wait_q(3);
    n_checks++; if (wbq[0].data !== 32'h11 || wbq[1].data !== 32'h22 || wbq[2].data !== 32'h33)
    begin
      $display("FAIL stall_order: got %h,%h,%h want 11,22,33",
               wbq[0].data, wbq[1].data, wbq[2].data); n_fail++; end
    n_checks++; if (retired !== 32'd3) begin
      $display("FAIL stall_retired: got %0d want 3", retired); n_fail++; end
  endtask

  task automatic test_reset_midflight();
    int w;
    wb_ready = 1'b1;
    send(4'd10, 5'd0, 5'd0, 5'd15, 32'hAB, 1'b1, 1'b1, w);
    send(4'd10, 5'd0, 5'd0, 5'd14, 32'hCD, 1'b1, 1'b1, w);
    n_checks++; if (wb_valid !== 1'b1 || retired === 32'd0) begin
      $display("FAIL mid_pre: got v=%b retired=%0d want 1,nonzero", wb_valid, retired);
      n_fail++; end
    reset_n = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || retired !== 32'd0 || uop_ready !== 1'b0) begin
      $display("FAIL mid_reset: got v=%b retired=%0d ready=%b want 0,0,0",
               wb_valid, retired, uop_ready); n_fail++; end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    wbq.delete();
    send(4'd10, 5'd0, 5'd15, 5'd0, 32'd0, 1'b0, 1'b0, w);
    send(4'd10, 5'd0, 5'd14, 5'd0, 32'd0, 1'b0, 1'b0, w);
    wait_q(2);
    n_checks++; if (wbq[0].data !== 32'd0 || wbq[1].data !== 32'd0) begin
      $display("FAIL mid_dest: got r15=%h r14=%h want 0,0", wbq[0].data, wbq[1].data);
      n_fail++; end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_back_to_back();
    test_alu();
    test_zero_reg();
    test_illegal();
    test_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
